// File: rtl/core_launcher.sv
// Run controller in front of the processor core: loads a byte image into data memory,
// pulses the core through reset and req, waits for done or a timeout, then dumps a result window.
module core_launcher #(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int DUMP_BASE = 64,
    parameter int DUMP_LEN  = 64,
    parameter int CW        = 16,
    parameter int TIMEOUT   = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat_in,
    input  logic [7:0]    mem_dat_out,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          timeout_err,
    output logic [CW-1:0] run_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CRST,
        RUN,
        DUMP
    } state_e;

    // The byte index must be able to hold the full length, one past the last index.
    localparam int MAXLEN = (LOAD_LEN > DUMP_LEN) ? LOAD_LEN : DUMP_LEN;
    localparam int KW     = (MAXLEN < 1) ? 1 : $clog2(MAXLEN + 1);

    localparam logic [KW-1:0] LOAD_LAST   = KW'(LOAD_LEN - 1);
    localparam logic [KW-1:0] DUMP_END    = KW'(DUMP_LEN);
    localparam logic [CW-1:0] RUN_LIMIT   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0] DUMP_BASE_A = AW'(DUMP_BASE);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   run_cycles_q, run_cycles_d;
    logic            timeout_err_q, timeout_err_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            core_req_q, core_req_d;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        run_cycles_d  = run_cycles_q;
        timeout_err_d = timeout_err_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        core_req_d    = 1'b0;
        in_ready      = 1'b0;
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_dat_in    = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    timeout_err_d = 1'b0;
                    run_cycles_d  = '0;
                    k_d           = '0;
                    state_d       = (LOAD_LEN == 0) ? CRST : LOAD;
                end
            end
            LOAD: begin
                in_ready   = 1'b1;
                mem_addr   = LOAD_BASE_A + AW'(k_q);
                mem_dat_in = in_data;
                mem_wr_en  = in_valid;
                if (in_valid) begin
                    k_d = k_q + 1'b1;
                    if (k_q == LOAD_LAST) state_d = CRST;
                end
            end
            CRST: begin
                core_req_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (run_cycles_q != CNT_MAX) run_cycles_d = run_cycles_q + 1'b1;
                // done takes priority over a timeout landing in the same cycle
                if (core_done || run_cycles_q == RUN_LIMIT) begin
                    if (!core_done) timeout_err_d = 1'b1;
                    k_d     = '0;
                    state_d = (DUMP_LEN == 0) ? IDLE : DUMP;
                end
            end
            DUMP: begin
                mem_addr = DUMP_BASE_A + AW'(k_q);
                if ((!out_valid_q || out_ready) && k_q < DUMP_END) begin
                    out_data_d  = mem_dat_out;
                    out_valid_d = 1'b1;
                    k_d         = k_q + 1'b1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            run_cycles_q  <= '0;
            timeout_err_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            core_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            run_cycles_q  <= run_cycles_d;
            timeout_err_q <= timeout_err_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            core_req_q    <= core_req_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign core_req    = core_req_q;
    assign timeout_err = timeout_err_q;
    assign run_cycles  = run_cycles_q;
    assign busy        = (state_q != IDLE);
    assign mem_sel     = (state_q != RUN);
    assign core_reset  = (state_q != RUN);

endmodule

// File: tb/tb_core_launcher.sv
// Directed bench for core_launcher: three instances cover the normal window, a wrapping
// load/dump window, and the zero-length case, each with its own data-memory model.
module tb_core_launcher;

    logic clk;
    logic reset;
    logic in_valid;
    logic [7:0] in_data;
    logic out_ready;
    logic core_done;

    int checks = 0;
    int errors = 0;

    // Instance A: LOAD 4 @0, DUMP 4 @0, TIMEOUT 20
    logic start_a, in_ready_a, out_valid_a, mem_sel_a, mem_wr_en_a;
    logic core_reset_a, core_req_a, busy_a, timeout_err_a;
    logic [7:0] out_data_a, mem_addr_a, mem_dat_in_a, mem_dat_out_a;
    logic [15:0] run_cycles_a;
    logic [7:0] mem_a [256] = '{default: 8'h00};
    int wcnt_a = 0;

    // Instance B: LOAD 4 @0xFE, DUMP 4 @0xFE (wrapping window)
    logic start_b, in_ready_b, out_valid_b, mem_sel_b, mem_wr_en_b;
    logic core_reset_b, core_req_b, busy_b, timeout_err_b;
    logic [7:0] out_data_b, mem_addr_b, mem_dat_in_b, mem_dat_out_b;
    logic [15:0] run_cycles_b;
    logic [7:0] mem_b [256] = '{default: 8'h00};
    int wcnt_b = 0;

    // Instance C: LOAD_LEN = DUMP_LEN = 0
    logic start_c, in_ready_c, out_valid_c, mem_sel_c, mem_wr_en_c;
    logic core_reset_c, core_req_c, busy_c, timeout_err_c;
    logic [7:0] out_data_c, mem_addr_c, mem_dat_in_c, mem_dat_out_c;
    logic [15:0] run_cycles_c;
    int wcnt_c = 0;
    bit ov_seen_c = 1'b0;

    core_launcher #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .DUMP_BASE(0), .DUMP_LEN(4),
                    .CW(16), .TIMEOUT(20)) u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .mem_sel(mem_sel_a), .mem_wr_en(mem_wr_en_a), .mem_addr(mem_addr_a),
        .mem_dat_in(mem_dat_in_a), .mem_dat_out(mem_dat_out_a),
        .core_reset(core_reset_a), .core_req(core_req_a), .core_done(core_done),
        .busy(busy_a), .timeout_err(timeout_err_a), .run_cycles(run_cycles_a)
    );

    core_launcher #(.AW(8), .LOAD_BASE(254), .LOAD_LEN(4), .DUMP_BASE(254), .DUMP_LEN(4),
                    .CW(16), .TIMEOUT(4000)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .mem_sel(mem_sel_b), .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b),
        .mem_dat_in(mem_dat_in_b), .mem_dat_out(mem_dat_out_b),
        .core_reset(core_reset_b), .core_req(core_req_b), .core_done(core_done),
        .busy(busy_b), .timeout_err(timeout_err_b), .run_cycles(run_cycles_b)
    );

    core_launcher #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(0), .DUMP_BASE(0), .DUMP_LEN(0),
                    .CW(16), .TIMEOUT(4000)) u_c (
        .clk(clk), .reset(reset), .start(start_c),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .mem_sel(mem_sel_c), .mem_wr_en(mem_wr_en_c), .mem_addr(mem_addr_c),
        .mem_dat_in(mem_dat_in_c), .mem_dat_out(mem_dat_out_c),
        .core_reset(core_reset_c), .core_req(core_req_c), .core_done(core_done),
        .busy(busy_c), .timeout_err(timeout_err_c), .run_cycles(run_cycles_c)
    );

    assign mem_dat_out_a = mem_a[mem_addr_a];
    assign mem_dat_out_b = mem_b[mem_addr_b];
    assign mem_dat_out_c = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-memory models: a write lands only while the launcher owns the port.
    always @(posedge clk) begin
        if (mem_sel_a && mem_wr_en_a) begin
            mem_a[mem_addr_a] <= mem_dat_in_a;
            wcnt_a <= wcnt_a + 1;
        end
        if (mem_sel_b && mem_wr_en_b) begin
            mem_b[mem_addr_b] <= mem_dat_in_b;
            wcnt_b <= wcnt_b + 1;
        end
        if (mem_wr_en_c) wcnt_c <= wcnt_c + 1;
        if (out_valid_c) ov_seen_c <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input bit use_b);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        check("start_in_ready", use_b ? in_ready_b : in_ready_a, 1);
        check("start_busy", use_b ? busy_b : busy_a, 1);
        check("start_timeout_clear", use_b ? timeout_err_b : timeout_err_a, 0);
        check("start_cycles_clear", use_b ? run_cycles_b : run_cycles_a, 0);
    endtask

    // Streams four bytes; optionally a stall cycle with a stray start before byte 2.
    task automatic load4(input bit use_b, input logic [7:0] base,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input bit gap);
        logic [7:0] bytes [4];
        logic [7:0] ea;
        int w0;
        bytes = '{b0, b1, b2, b3};
        w0 = use_b ? wcnt_b : wcnt_a;
        for (int i = 0; i < 4; i++) begin
            if (gap && i == 2) begin
                in_valid = 1'b0;
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
                #1;
                check("load_stall_no_write", use_b ? mem_wr_en_b : mem_wr_en_a, 0);
                tick();
                start_a = 1'b0;
                start_b = 1'b0;
            end
            ea = base + 8'(i);
            in_valid = 1'b1;
            in_data  = bytes[i];
            #1;
            check("load_addr", use_b ? mem_addr_b : mem_addr_a, ea);
            check("load_wr_en", use_b ? mem_wr_en_b : mem_wr_en_a, 1);
            tick();
        end
        in_valid = 1'b0;
        check("crst_in_ready", use_b ? in_ready_b : in_ready_a, 0);
        check("crst_busy", use_b ? busy_b : busy_a, 1);
        check("crst_core_reset", use_b ? core_reset_b : core_reset_a, 1);
        check("crst_core_req", use_b ? core_req_b : core_req_a, 0);
        check("load_write_count", (use_b ? wcnt_b : wcnt_a) - w0, 4);
        for (int i = 0; i < 4; i++) begin
            ea = base + 8'(i);
            check("load_mem", use_b ? mem_b[ea] : mem_a[ea], bytes[i]);
        end
    endtask

    // Called in CRST; the core model raises done during RUN cycle n (1-based).
    task automatic run_for(input bit use_b, input int n);
        tick();
        check("run_core_req", use_b ? core_req_b : core_req_a, 1);
        check("run_core_reset", use_b ? core_reset_b : core_reset_a, 0);
        check("run_mem_sel", use_b ? mem_sel_b : mem_sel_a, 0);
        for (int i = 1; i < n; i++) begin
            if (i == 2) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            if (i == 1) check("run_req_one_cycle", use_b ? core_req_b : core_req_a, 0);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("run_cycles", use_b ? run_cycles_b : run_cycles_a, n);
        check("run_timeout_err", use_b ? timeout_err_b : timeout_err_a, 0);
        check("exit_mem_sel", use_b ? mem_sel_b : mem_sel_a, 1);
        check("exit_out_valid", use_b ? out_valid_b : out_valid_a, 0);
    endtask

    // Called on the first DUMP cycle; stall applies out_ready = 1,0,0,1 repeating.
    task automatic collect(input bit use_b, input bit stall,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp [4];
        logic [7:0] got [$];
        logic       ov;
        logic [7:0] od;
        logic [7:0] held_data;
        bit         held;
        int         cyc;
        int         first_valid;
        exp = '{b0, b1, b2, b3};
        got = {};
        held = 1'b0;
        held_data = 8'h00;
        first_valid = -1;
        cyc = 0;
        while (cyc < 60) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            ov = use_b ? out_valid_b : out_valid_a;
            od = use_b ? out_data_b : out_data_a;
            if (held) begin
                check("dump_hold_valid", ov, 1);
                check("dump_hold_data", od, held_data);
            end
            if (ov && first_valid < 0) first_valid = cyc;
            if (ov && out_ready) got.push_back(od);
            held = ov && !out_ready;
            held_data = od;
            tick();
            cyc++;
            if (!(use_b ? busy_b : busy_a)) break;
        end
        out_ready = 1'b0;
        check("dump_finished_in_budget", use_b ? busy_b : busy_a, 0);
        check("dump_first_valid_cycle", first_valid, 1);
        if (!stall) check("dump_total_cycles", cyc, 5);
        check("dump_byte_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check("dump_byte", got[i], exp[i]);
        check("dump_end_out_valid", use_b ? out_valid_b : out_valid_a, 0);
    endtask

    task automatic check_idle_after_reset(input string tag);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_in_ready"}, in_ready_a, 0);
        check({tag, "_out_valid"}, out_valid_a, 0);
        check({tag, "_core_reset"}, core_reset_a, 1);
        check({tag, "_mem_sel"}, mem_sel_a, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; core_done = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_busy", busy_a, 0);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_mem_wr_en", mem_wr_en_a, 0);
        check("rst_core_req", core_req_a, 0);
        check("rst_timeout_err", timeout_err_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_mem_addr", mem_addr_a, 0);
        check("rst_run_cycles", run_cycles_a, 0);
        check("rst_mem_sel", mem_sel_a, 1);
        check("rst_core_reset", core_reset_a, 1);
        reset = 1'b0;
        tick();

        // Basic run: done on RUN cycle 10, dump at full rate
        start_run(0);
        load4(0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        run_for(0, 10);
        check("dump_entry_busy", busy_a, 1);
        collect(0, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        check("idle_run_cycles_stable", run_cycles_a, 10);

        // Load with a stall and a stray start, dump with out_ready toggling
        start_run(0);
        load4(0, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1);
        run_for(0, 5);
        collect(0, 1'b1, 8'hA1, 8'hA2, 8'hA3, 8'hA4);

        // Timeout: core never finishes
        start_run(0);
        load4(0, 8'h00, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 1'b0);
        tick();
        n = 0;
        while (!mem_sel_a && n < 100) begin
            n++;
            tick();
        end
        check("timeout_run_length", n, 20);
        check("timeout_err_set", timeout_err_a, 1);
        check("timeout_run_cycles", run_cycles_a, 20);
        collect(0, 1'b0, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
        check("timeout_err_sticky", timeout_err_a, 1);

        // done on RUN cycle 20, same cycle as the timeout: done wins
        start_run(0);
        load4(0, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        run_for(0, 20);
        collect(0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);

        // Reset mid-LOAD after two bytes
        start_run(0);
        in_valid = 1'b1; in_data = 8'hE1; tick();
        in_data = 8'hE2; tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_after_reset("rst_load");

        // Reset mid-DUMP while a byte is held
        start_run(0);
        load4(0, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b0);
        run_for(0, 3);
        out_ready = 1'b0;
        tick();
        tick();
        check("dump_held_before_reset", out_valid_a, 1);
        check("dump_held_data", out_data_a, 8'hC1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_after_reset("rst_dump");
        check("rst_dump_run_cycles", run_cycles_a, 0);
        check("rst_dump_out_data", out_data_a, 0);

        // Wrapping window on instance B
        start_run(1);
        load4(1, 8'hFE, 8'h91, 8'h92, 8'h93, 8'h94, 1'b0);
        check("wrap_untouched", mem_b[2], 8'h00);
        run_for(1, 2);
        collect(1, 1'b0, 8'h91, 8'h92, 8'h93, 8'h94);

        // Zero-length load and dump on instance C
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("zero_crst_busy", busy_c, 1);
        check("zero_crst_in_ready", in_ready_c, 0);
        check("zero_crst_core_reset", core_reset_c, 1);
        tick();
        check("zero_run_core_req", core_req_c, 1);
        check("zero_run_mem_sel", mem_sel_c, 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("zero_idle_busy", busy_c, 0);
        check("zero_run_cycles", run_cycles_c, 1);
        check("zero_mem_sel", mem_sel_c, 1);
        tick();
        tick();
        check("zero_no_writes", wcnt_c, 0);
        check("zero_no_out_valid", ov_seen_c, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_launcher.md
# core_launcher

Run controller that sits directly upstream of the processor core's top level. It streams a byte image into the core's data memory through a valid/ready input port, then holds the core in reset for one cycle. It next pulses the core's `req` and counts cycles until the core asserts `done` (or a timeout expires). Finally it streams a result window out of data memory through a valid/ready output port. While the core runs, data-memory ownership passes to the core via `mem_sel`.

## Interface
Parameters:
- AW, 8, data-memory address width.
- LOAD_BASE, 0, first data-memory address written during load.
- LOAD_LEN, 64, number of bytes loaded (0 allowed).
- DUMP_BASE, 64, first data-memory address read during dump.
- DUMP_LEN, 64, number of bytes dumped (0 allowed).
- CW, 16, cycle-counter width.
- TIMEOUT, 4000, maximum RUN cycles before abort (must be < 2^CW).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- in_valid  in  1  load byte valid.
- in_ready  out  1  load byte accepted this cycle when `in_valid` is also high.
- in_data  in  8  load byte.
- out_valid  out  1  dump byte valid.
- out_ready  in  1  downstream accepts the dump byte.
- out_data  out  8  dump byte, registered.
- mem_sel  out  1  1 = launcher drives the data-memory port, 0 = core drives it.
- mem_wr_en  out  1  data-memory write enable.
- mem_addr  out  AW  data-memory address.
- mem_dat_in  out  8  data-memory write data.
- mem_dat_out  in  8  data-memory read data; combinational from `mem_addr`.
- core_reset  out  1  drives the core's `reset`.
- core_req  out  1  drives the core's `req`.
- core_done  in  1  the core's `done`.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; the last run hit TIMEOUT.
- run_cycles  out  CW  RUN cycle count of the last run.

## Operation
- States: IDLE, LOAD, CRST, RUN, DUMP.
- Reset values:
  - state = IDLE.
  - in_ready, out_valid, mem_wr_en, core_req, busy, timeout_err = 0.
  - out_data, mem_addr, run_cycles = 0.
  - mem_sel = 1, core_reset = 1.
- `core_reset` = 1 in every state except RUN.
- `mem_sel` = 0 only in RUN.
- IDLE:
  - On `start`, clear `timeout_err` and `run_cycles`, and clear the byte index k = 0.
  - Go to LOAD, or to CRST if LOAD_LEN = 0.
  - `start` outside IDLE is ignored.
- LOAD:
  - `in_ready` = 1, combinational from state.
  - `mem_addr` = (LOAD_BASE + k) mod 2^AW.
  - `mem_dat_in` = `in_data`.
  - `mem_wr_en` = `in_valid`.
  - Each accepted byte increments k. Acceptance of byte LOAD_LEN-1 moves to CRST.
  - No bubbles are inserted; `in_valid` low stalls without side effects.
- CRST:
  - Exactly one cycle, `core_reset` = 1.
  - Go to RUN with `core_req` = 1 registered for the first RUN cycle only.
- RUN:
  - `run_cycles` increments each cycle, saturating at 2^CW-1.
  - `core_done` = 1: go to DUMP (k = 0), or to IDLE if DUMP_LEN = 0.
  - Else if `run_cycles` = TIMEOUT-1: set `timeout_err`, then take the same DUMP/IDLE branch.
  - `core_done` and timeout in the same cycle: done wins and `timeout_err` stays 0.
- DUMP:
  - `mem_addr` = (DUMP_BASE + k) mod 2^AW.
  - The output register loads `mem_dat_out` and sets `out_valid` whenever (!out_valid || out_ready) and k < DUMP_LEN, then increments k.
  - `out_data`/`out_valid` are held stable while out_valid && !out_ready.
  - When the byte for k = DUMP_LEN-1 is handed off (out_valid && out_ready) and no further byte is pending: `out_valid` drops and the block goes to IDLE.
- Address arithmetic wraps modulo 2^AW: LOAD_BASE + LOAD_LEN > 2^AW wraps to address 0.
- `reset` in any state returns to IDLE next cycle with reset values. The partial load/dump is discarded and the core is held in reset.

## Timing
- `start` in cycle t: LOAD (`in_ready` = 1) in t+1.
- Load throughput: 1 byte/cycle.
- Last load byte accepted in cycle t: CRST in t+1, RUN with `core_req` = 1 in t+2, `core_reset` = 0 from t+2.
- `core_done` sampled high in cycle t: DUMP in t+1, first `out_valid` in t+2.
- Dump throughput: 1 byte/cycle with `out_ready` held high.
- `run_cycles` is final and stable from the cycle after RUN exits until the next `start`.
- TIMEOUT abort exits RUN after exactly TIMEOUT RUN cycles.

## Test plan
- LOAD_LEN=4, DUMP_LEN=4, DUMP_BASE=LOAD_BASE=0, core model asserts done 10 cycles after req, bytes 0x11,0x22,0x33,0x44 -> memory writes at addresses 0..3 and run_cycles=10. The dump sees the same four bytes; timeout_err=0.
- out_ready toggled 1,0,0,1,... during dump -> out_data stable while stalled, no byte dropped or duplicated, DUMP_LEN bytes total.
- Core never asserts done, TIMEOUT=20 -> exit after 20 RUN cycles, timeout_err=1, run_cycles=20, dump still occurs. core_done on cycle 20 exactly -> timeout_err=0.
- LOAD_BASE=0xFE, LOAD_LEN=4 -> writes to 0xFE, 0xFF, 0x00, 0x01. LOAD_LEN=0 and DUMP_LEN=0 -> IDLE→CRST→RUN→IDLE with no memory writes and out_valid never high.
- reset asserted mid-LOAD after 2 bytes and again mid-DUMP -> next cycle IDLE, in_ready=0, out_valid=0, core_reset=1, mem_sel=1. `start` pulsed while busy -> no effect.
